// File: rtl/ram64kb_arbiter.sv
// Round-robin arbiter and sequencer that shares one 64K x 8 single-port RAM
// between two req/ack requesters; every grant becomes exactly one RAM access.
module ram64kb_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0,
    input  logic        rw0,
    input  logic [15:0] addr0,
    input  logic [7:0]  wdata0,
    output logic        ack0,
    output logic [7:0]  rdata0,

    input  logic        req1,
    input  logic        rw1,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata1,
    output logic        ack1,
    output logic [7:0]  rdata1,

    output logic        ram_enable,
    output logic        ram_readWrite,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_dataIn,
    input  logic [7:0]  ram_dataOut,

    output logic        busy,
    output logic        grant_id
);

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_rw;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_grant;
    logic        r_last_grant;
    logic [2:0]  r_wait_cnt;
    logic [7:0]  r_rdata0;
    logic [7:0]  r_rdata1;

    logic        w_any_req;
    logic        w_winner;
    logic        w_start;
    logic        w_capture;
    logic        w_sel_rw;
    logic [15:0] w_sel_addr;
    logic [7:0]  w_sel_wdata;

    // On a tie the requester that did not win last time takes the RAM.
    assign w_any_req   = req0 | req1;
    assign w_winner    = (req0 && req1) ? ~r_last_grant : req1;
    assign w_start     = (r_state == S_IDLE) && w_any_req;
    assign w_capture   = (r_state == S_WAIT) && (r_wait_cnt == 3'd1);

    assign w_sel_rw    = w_winner ? rw1    : rw0;
    assign w_sel_addr  = w_winner ? addr1  : addr0;
    assign w_sel_wdata = w_winner ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        ram_enable    = 1'b0;
        ram_readWrite = 1'b0;
        ram_addr      = '0;
        ram_dataIn    = '0;
        ack0          = 1'b0;
        ack1          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ram_enable    = 1'b1;
                ram_readWrite = r_rw;
                ram_addr      = r_addr;
                ram_dataIn    = r_wdata;
                w_next_state  = r_rw ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (r_wait_cnt == 3'd1) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                ack0         = ~r_grant;
                ack1         = r_grant;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request fields are frozen at grant time so later changes on the
    // requester side cannot disturb the access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_start) begin
            r_rw         <= w_sel_rw;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wait_cnt <= LAT;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
        end
    end

    // Read data is captured as-is, unknowns included, on the last wait cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_capture) begin
            if (r_grant) begin
                r_rdata1 <= ram_dataOut;
            end else begin
                r_rdata0 <= ram_dataOut;
            end
        end
    end

    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_grant;

endmodule
